id_ex_stage: RTL and testbench

ID/EX pipeline register and operand-forwarding stage that sits directly upstream of the `alu`. It captures one decoded instruction per cycle, resolves RAW hazards by bypassing from the EX/MEM and MEM/WB buses, and selects the ALU operands and control. It also asserts `load_use_stall` to freeze fetch and decode. `alu_d1`, `alu_d2` and `alu_control` connect directly to the ALU inputs `d1`, `d2` and `control`.

---
 rtl/pipe_pkg.sv | 14 +
 rtl/fwd_mux.sv | 29 ++
 rtl/id_ex_stage.sv | 177 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline constants: datapath/index widths and ALU operand-select encodings.
package pipe_pkg;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_IDX_W  = 5;
  localparam int unsigned ALU_CTRL_W = 4;

  localparam logic [1:0] A_SEL_RS1  = 2'b00;
  localparam logic [1:0] A_SEL_PC   = 2'b01;
  localparam logic [1:0] A_SEL_ZERO = 2'b10;
  localparam logic [1:0] A_SEL_RS1B = 2'b11;

  localparam logic B_SEL_RS2 = 1'b0;
  localparam logic B_SEL_IMM = 1'b1;
endpackage

// File: rtl/fwd_mux.sv
// Priority bypass for one source operand: EX/MEM beats MEM/WB beats stored data.
module fwd_mux
  import pipe_pkg::*;
#(
  parameter int unsigned W = XLEN
) (
  input  logic [REG_IDX_W-1:0] rs_i,
  input  logic [W-1:0]         stored_i,
  input  logic [REG_IDX_W-1:0] exmem_rd_i,
  input  logic                 exmem_we_i,
  input  logic [W-1:0]         exmem_result_i,
  input  logic [REG_IDX_W-1:0] memwb_rd_i,
  input  logic                 memwb_we_i,
  input  logic [W-1:0]         memwb_result_i,
  output logic [W-1:0]         data_o
);
  logic hit_exmem;
  logic hit_memwb;

  // x0 is hardwired; never bypass into it.
  assign hit_exmem = exmem_we_i && (exmem_rd_i != '0) && (exmem_rd_i == rs_i);
  assign hit_memwb = memwb_we_i && (memwb_rd_i != '0) && (memwb_rd_i == rs_i);

  always_comb begin
    data_o = stored_i;
    if (hit_exmem)      data_o = exmem_result_i;
    else if (hit_memwb) data_o = memwb_result_i;
  end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with RAW bypassing, ALU operand selection and
// load-use hazard detection.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN = pipe_pkg::XLEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [XLEN-1:0]       id_rs1_data,
  input  logic [XLEN-1:0]       id_rs2_data,
  input  logic [XLEN-1:0]       id_imm,
  input  logic [XLEN-1:0]       id_pc,
  input  logic [REG_IDX_W-1:0]  id_rs1,
  input  logic [REG_IDX_W-1:0]  id_rs2,
  input  logic [REG_IDX_W-1:0]  id_rd,
  input  logic [ALU_CTRL_W-1:0] id_alu_ctrl,
  input  logic [1:0]            id_a_sel,
  input  logic                  id_b_sel,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [REG_IDX_W-1:0]  exmem_rd,
  input  logic                  exmem_reg_write,
  input  logic [XLEN-1:0]       exmem_result,
  input  logic [REG_IDX_W-1:0]  memwb_rd,
  input  logic                  memwb_reg_write,
  input  logic [XLEN-1:0]       memwb_result,
  output logic                  ex_valid,
  output logic [XLEN-1:0]       alu_d1,
  output logic [XLEN-1:0]       alu_d2,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [XLEN-1:0]       ex_rs2_fwd,
  output logic [REG_IDX_W-1:0]  ex_rd,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  load_use_stall
);
  logic                  valid_q,     valid_d;
  logic [XLEN-1:0]       rs1_data_q,  rs1_data_d;
  logic [XLEN-1:0]       rs2_data_q,  rs2_data_d;
  logic [XLEN-1:0]       imm_q,       imm_d;
  logic [XLEN-1:0]       pc_q,        pc_d;
  logic [REG_IDX_W-1:0]  rs1_q,       rs1_d;
  logic [REG_IDX_W-1:0]  rs2_q,       rs2_d;
  logic [REG_IDX_W-1:0]  rd_q,        rd_d;
  logic [ALU_CTRL_W-1:0] alu_ctrl_q,  alu_ctrl_d;
  logic [1:0]            a_sel_q,     a_sel_d;
  logic                  b_sel_q,     b_sel_d;
  logic                  reg_write_q, reg_write_d;
  logic                  mem_read_q,  mem_read_d;

  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  fwd_mux #(.W(XLEN)) u_fwd_rs1 (
    .rs_i           (rs1_q),
    .stored_i       (rs1_data_q),
    .exmem_rd_i     (exmem_rd),
    .exmem_we_i     (exmem_reg_write),
    .exmem_result_i (exmem_result),
    .memwb_rd_i     (memwb_rd),
    .memwb_we_i     (memwb_reg_write),
    .memwb_result_i (memwb_result),
    .data_o         (fwd_rs1)
  );

  fwd_mux #(.W(XLEN)) u_fwd_rs2 (
    .rs_i           (rs2_q),
    .stored_i       (rs2_data_q),
    .exmem_rd_i     (exmem_rd),
    .exmem_we_i     (exmem_reg_write),
    .exmem_result_i (exmem_result),
    .memwb_rd_i     (memwb_rd),
    .memwb_we_i     (memwb_reg_write),
    .memwb_result_i (memwb_result),
    .data_o         (fwd_rs2)
  );

  assign load_use_stall = valid_q && mem_read_q && (rd_q != '0) &&
                          ((rd_q == id_rs1) || (rd_q == id_rs2)) &&
                          id_valid && !flush;

  always_comb begin
    valid_d     = valid_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    pc_d        = pc_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    alu_ctrl_d  = alu_ctrl_q;
    a_sel_d     = a_sel_q;
    b_sel_d     = b_sel_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    if (flush) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
    end else if (stall) begin
      // Hold, but latch bypassed values so a producer retiring now is not lost.
      rs1_data_d = fwd_rs1;
      rs2_data_d = fwd_rs2;
    end else if (load_use_stall) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
    end else begin
      valid_d     = id_valid;
      rs1_data_d  = id_rs1_data;
      rs2_data_d  = id_rs2_data;
      imm_d       = id_imm;
      pc_d        = id_pc;
      rs1_d       = id_rs1;
      rs2_d       = id_rs2;
      rd_d        = id_rd;
      alu_ctrl_d  = id_alu_ctrl;
      a_sel_d     = id_a_sel;
      b_sel_d     = id_b_sel;
      reg_write_d = id_reg_write & id_valid;
      mem_read_d  = id_mem_read & id_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      alu_ctrl_q  <= '0;
      a_sel_q     <= '0;
      b_sel_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      pc_q        <= pc_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      alu_ctrl_q  <= alu_ctrl_d;
      a_sel_q     <= a_sel_d;
      b_sel_q     <= b_sel_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
    end
  end

  always_comb begin
    alu_d1 = fwd_rs1;
    case (a_sel_q)
      A_SEL_PC:   alu_d1 = pc_q;
      A_SEL_ZERO: alu_d1 = '0;
      default:    alu_d1 = fwd_rs1;
    endcase
  end

  assign alu_d2       = (b_sel_q == B_SEL_IMM) ? imm_q : fwd_rs2;
  assign ex_rs2_fwd   = fwd_rs2;
  assign alu_control  = alu_ctrl_q;
  assign ex_valid     = valid_q;
  assign ex_rd        = rd_q;
  assign ex_reg_write = reg_write_q & valid_q;
  assign ex_mem_read  = mem_read_q & valid_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expectations queued when stimulus is driven,
// popped and compared when the DUT output is sampled.
module tb_id_ex_stage;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alu_ctrl;
  logic [1:0]  id_a_sel;
  logic        id_b_sel, id_reg_write, id_mem_read;
  logic        stall, flush;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        exmem_reg_write, memwb_reg_write;
  logic [31:0] exmem_result, memwb_result;
  logic        ex_valid;
  logic [31:0] alu_d1, alu_d2, ex_rs2_fwd;
  logic [3:0]  alu_control;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, load_use_stall;

  id_ex_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_alu_ctrl(id_alu_ctrl), .id_a_sel(id_a_sel), .id_b_sel(id_b_sel),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .stall(stall), .flush(flush),
    .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
    .ex_valid(ex_valid), .alu_d1(alu_d1), .alu_d2(alu_d2), .alu_control(alu_control),
    .ex_rs2_fwd(ex_rs2_fwd), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .load_use_stall(load_use_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_bypass();
    exmem_rd = '0; exmem_reg_write = 1'b0; exmem_result = '0;
    memwb_rd = '0; memwb_reg_write = 1'b0; memwb_result = '0;
  endtask

  task automatic drive_id(input logic [4:0] rs1, input logic [31:0] d1,
                          input logic [4:0] rs2, input logic [31:0] d2,
                          input logic [4:0] rd, input logic [3:0] ctrl,
                          input logic [1:0] asel, input logic bsel,
                          input logic rw, input logic mr);
    id_valid = 1'b1;
    id_rs1 = rs1; id_rs1_data = d1;
    id_rs2 = rs2; id_rs2_data = d2;
    id_rd = rd; id_alu_ctrl = ctrl;
    id_a_sel = asel; id_b_sel = bsel;
    id_reg_write = rw; id_mem_read = mr;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    id_valid = 1'b0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0; id_pc = '0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_alu_ctrl = '0; id_a_sel = '0;
    id_b_sel = 1'b0; id_reg_write = 1'b0; id_mem_read = 1'b0;
    clear_bypass();
    tick(); tick();
    expect_val("rst_ex_valid", 32'd0);    check({31'd0, ex_valid});
    expect_val("rst_alu_control", 32'd0); check({28'd0, alu_control});
    expect_val("rst_lus", 32'd0);         check({31'd0, load_use_stall});
    rst = 1'b0;

    // Pass-through
    drive_id(5'd1, 32'hF31474A1, 5'd2, 32'h7214673C, 5'd3, 4'b0110, A_SEL_RS1, B_SEL_RS2, 1'b1, 1'b0);
    id_imm = 32'h0000_0010; id_pc = 32'h0000_1000;
    expect_val("pt_d1", 32'hF31474A1);
    expect_val("pt_d2", 32'h7214673C);
    expect_val("pt_ctrl", 32'h6);
    expect_val("pt_valid", 32'd1);
    expect_val("pt_rd", 32'd3);
    expect_val("pt_rw", 32'd1);
    tick();
    check(alu_d1); check(alu_d2); check({28'd0, alu_control});
    check({31'd0, ex_valid}); check({27'd0, ex_rd}); check({31'd0, ex_reg_write});

    // Operand select: pc / imm, then zero / rs1-alias
    id_a_sel = A_SEL_PC; id_b_sel = B_SEL_IMM;
    expect_val("sel_pc", 32'h0000_1000);
    expect_val("sel_imm", 32'h0000_0010);
    expect_val("sel_rs2_store", 32'h7214673C);
    tick();
    check(alu_d1); check(alu_d2); check(ex_rs2_fwd);
    id_a_sel = A_SEL_ZERO;
    expect_val("sel_zero", 32'd0);
    tick(); check(alu_d1);
    id_a_sel = A_SEL_RS1B; id_b_sel = B_SEL_RS2;
    expect_val("sel_rs1_alias", 32'hF31474A1);
    tick(); check(alu_d1);

    // Forward priority
    drive_id(5'd5, 32'h12345678, 5'd6, 32'h66666666, 5'd10, 4'b0000, A_SEL_RS1, B_SEL_RS2, 1'b1, 1'b0);
    tick();
    exmem_rd = 5'd5; exmem_reg_write = 1'b1; exmem_result = 32'h11111111;
    memwb_rd = 5'd5; memwb_reg_write = 1'b1; memwb_result = 32'h22222222;
    expect_val("fwd_exmem_wins", 32'h11111111);
    expect_val("fwd_rs2_untouched", 32'h66666666);
    #1; check(alu_d1); check(alu_d2);
    exmem_reg_write = 1'b0;
    expect_val("fwd_memwb", 32'h22222222);
    #1; check(alu_d1);
    memwb_rd = 5'd6;
    expect_val("fwd_memwb_rs2", 32'h22222222);
    expect_val("fwd_memwb_rs1_off", 32'h12345678);
    #1; check(ex_rs2_fwd); check(alu_d1);
    clear_bypass();

    drive_id(5'd0, 32'hCAFEF00D, 5'd6, 32'h0, 5'd10, 4'b0000, A_SEL_RS1, B_SEL_RS2, 1'b1, 1'b0);
    tick();
    exmem_rd = 5'd0; exmem_reg_write = 1'b1; exmem_result = 32'h11111111;
    memwb_rd = 5'd0; memwb_reg_write = 1'b1; memwb_result = 32'h22222222;
    expect_val("fwd_x0_stored", 32'hCAFEF00D);
    #1; check(alu_d1);
    clear_bypass();

    // Load-use
    drive_id(5'd1, 32'h0, 5'd2, 32'h0, 5'd7, 4'b0000, A_SEL_RS1, B_SEL_RS2, 1'b1, 1'b1);
    tick();
    drive_id(5'd8, 32'h88888888, 5'd7, 32'h77777777, 5'd9, 4'b0001, A_SEL_RS1, B_SEL_RS2, 1'b1, 1'b0);
    expect_val("lu_stall", 32'd1);
    #1; check({31'd0, load_use_stall});
    flush = 1'b1;
    expect_val("lu_masked_by_flush", 32'd0);
    #1; check({31'd0, load_use_stall});
    flush = 1'b0;
    expect_val("lu_bubble_valid", 32'd0);
    expect_val("lu_bubble_mr", 32'd0);
    expect_val("lu_bubble_rw", 32'd0);
    expect_val("lu_released", 32'd0);
    tick();
    check({31'd0, ex_valid}); check({31'd0, ex_mem_read});
    check({31'd0, ex_reg_write}); check({31'd0, load_use_stall});
    expect_val("lu_resume_valid", 32'd1);
    expect_val("lu_resume_rd", 32'd9);
    expect_val("lu_resume_d2", 32'h77777777);
    tick();
    check({31'd0, ex_valid}); check({27'd0, ex_rd}); check(alu_d2);

    // Stall refresh
    drive_id(5'd4, 32'h01010101, 5'd2, 32'h0, 5'd11, 4'b0010, A_SEL_RS1, B_SEL_RS2, 1'b1, 1'b0);
    tick();
    stall = 1'b1;
    drive_id(5'd12, 32'hDEADBEEF, 5'd13, 32'hDEADBEEF, 5'd14, 4'b1111, A_SEL_PC, B_SEL_IMM, 1'b1, 1'b0);
    memwb_rd = 5'd4; memwb_reg_write = 1'b1; memwb_result = 32'hAAAA5555;
    tick();
    clear_bypass();
    tick();
    stall = 1'b0;
    expect_val("stall_refresh_d1", 32'hAAAA5555);
    expect_val("stall_hold_ctrl", 32'h2);
    expect_val("stall_hold_valid", 32'd1);
    #1; check(alu_d1); check({28'd0, alu_control}); check({31'd0, ex_valid});

    // Flush vs stall
    stall = 1'b1; flush = 1'b1;
    expect_val("flush_valid", 32'd0);
    expect_val("flush_rw", 32'd0);
    tick();
    check({31'd0, ex_valid}); check({31'd0, ex_reg_write});
    stall = 1'b0; flush = 1'b0;
    drive_id(5'd3, 32'h5A5A5A5A, 5'd2, 32'h0, 5'd15, 4'b0101, A_SEL_RS1, B_SEL_RS2, 1'b1, 1'b0);
    expect_val("post_flush_valid", 32'd1);
    expect_val("post_flush_d1", 32'h5A5A5A5A);
    expect_val("post_flush_rw", 32'd1);
    tick();
    check({31'd0, ex_valid}); check(alu_d1); check({31'd0, ex_reg_write});

    // Asynchronous reset mid-cycle
    #2 rst = 1'b1;
    expect_val("arst_valid", 32'd0);
    expect_val("arst_d1", 32'd0);
    expect_val("arst_d2", 32'd0);
    expect_val("arst_ctrl", 32'd0);
    #1; check({31'd0, ex_valid}); check(alu_d1); check(alu_d2); check({28'd0, alu_control});
    #2 rst = 1'b0;
    expect_val("post_rst_capture", 32'd1);
    tick(); check({31'd0, ex_valid});

    if (sb.size() != 0) begin
      failures++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
